mcycle_unit: RTL
================

# mcycle_unit

Parametrised multi-cycle multiply/divide execution unit for the pipelined core's E stage. It supersedes the fixed 32-bit multiplier and its separate destination-tag register. It adds signed/unsigned divide, a full-width second result, a valid/ack writeback handshake and an abort input. It also generates the decode-stage RAW hazard against its pending destination register, so the top level no longer builds the multi-cycle stall compare.

## Interface
- WIDTH, 32: operand/result width; must be ≥ 4 and even.
- TAG_W, 4: destination register tag width.
- CLK  in  1  clock; all state changes on the rising edge.
- Reset  in  1  asynchronous, active-low reset (0 = reset).
- Start  in  1  launch request; sampled only in IDLE, or in HOLD when ResultAck=1.
- Op  in  2  00 MULU, 01 MULS, 10 DIVU, 11 DIVS.
- Operand1  in  WIDTH  multiplicand / dividend.
- Operand2  in  WIDTH  multiplier / divisor.
- TagIn  in  TAG_W  destination register, captured with Start.
- RA1, RA2  in  TAG_W  decode-stage source register addresses.
- ResultAck  in  1  writeback consumed the result.
- Abort  in  1  synchronous cancel (branch flush).
- Busy  out  1  high in RUN, FIX and HOLD.
- ResultValid  out  1  high in HOLD only.
- Result  out  WIDTH  product low half / quotient.
- Result2  out  WIDTH  product high half / remainder.
- TagOut  out  TAG_W  captured TagIn.
- DivByZero  out  1  valid with ResultValid.
- Hazard  out  1  Busy && (TagOut==RA1 || TagOut==RA2).

## Operation
States:
- IDLE:
  - Start → RUN. Capture operands as magnitudes when the op is signed; record sign flags, Op and TagIn; clear the counter.
  - Start with DIVx and Operand2==0 → FIX directly.
- RUN: one radix-2 step per cycle.
  - Multiply: shift-add over a 2·WIDTH accumulator.
  - Divide: restoring shift-subtract.
  - Counter reaching WIDTH-1 → FIX.
- FIX: apply signs.
  - MULS: negate the 2·WIDTH product if the operand signs differ.
  - DIVS: quotient sign = sign1 XOR sign2; remainder sign = dividend sign.
  - Next state → HOLD.
- HOLD: outputs stable, ResultValid=1.
  - ResultAck → IDLE.
  - ResultAck && Start → RUN, back to back, capturing the new operands.

Arithmetic and boundary behaviour:
- Divide by zero: Result = all ones, Result2 = Operand1, DivByZero=1.
- DIVS of MIN/−1: Result = MIN, Result2 = 0, no flag.
- Start in RUN/FIX, or in HOLD without ResultAck: ignored. The caller stalls on Busy.
- Abort in any state → IDLE next edge; ResultValid and Hazard drop next cycle. Abort beats Start and ResultAck.
- Hazard remains asserted through HOLD until the ack edge.

## Timing
- Reset values: state IDLE; Busy, ResultValid, DivByZero, Hazard = 0; Result, Result2, TagOut = 0.
- Latency: ResultValid rises WIDTH+1 edges after the Start-sampling edge; for WIDTH=32 that is edge 33.
- Divide by zero: ResultValid rises 1 edge after the Start-sampling edge.
- Throughput: one op per WIDTH+1 cycles with same-cycle Ack+Start.
- Hazard, Busy and ResultValid are registered-state decodes with no combinational path from Start. Hazard is combinational from RA1/RA2.
- Asynchronous reset mid-operation discards all state immediately.

## Configuration
- MCYCLE_EARLY_EXIT_EN defined: MULU/MULS leave RUN for FIX as soon as the remaining multiplier bits are zero, and the accumulator is aligned by the residual shift count. Latency is variable, between 1 and WIDTH+1 edges. Divide latency is unchanged.
- MCYCLE_EARLY_EXIT_EN undefined: fixed WIDTH+1 latency for all non-zero-divisor ops.

## Structure
- Package mcycle_pkg:
  - op enum (MULU, MULS, DIVU, DIVS).
  - state enum (IDLE, RUN, FIX, HOLD).
  - Helper function for two's-complement magnitude.
- Sub-module mcycle_step: combinational single-iteration datapath for one multiply/divide step. The parent owns the registers, counter and FSM.

## Test plan
- MULU 0xFFFFFFFF×0xFFFFFFFF, TagIn=7 → Result=0x00000001, Result2=0xFFFFFFFE, TagOut=7, ResultValid at edge 33 (without MCYCLE_EARLY_EXIT_EN).
- MULS −3×7 → Result=0xFFFFFFEB, Result2=0xFFFFFFFF.
- DIVS −7/2 → Result=0xFFFFFFFD, Result2=0xFFFFFFFF.
- DIVU 5/0 → ResultValid at edge 1, Result=0xFFFFFFFF, Result2=5, DivByZero=1.
- Hazard check:
  - TagIn=3 running: RA1=3 → Hazard=1; RA1=4, RA2=5 → Hazard=0.
  - Still 1 in HOLD; 0 the cycle after the ResultAck edge.
- Abort at RUN cycle 10 → IDLE and Busy=0 next cycle; ResultValid never rises.
- Ack+Start together in HOLD → new op valid WIDTH+1 edges later.
- Reset pulled low mid-RUN → all outputs 0 immediately.

Source files
------------

// File: rtl/mcycle_pkg.sv
// Shared types and helpers for the multi-cycle multiply/divide unit.
// Helper widths support WIDTH up to 64.
package mcycle_pkg;

  localparam int MAG_W = 128;

  typedef enum logic [1:0] {
    OP_MULU = 2'b00,
    OP_MULS = 2'b01,
    OP_DIVU = 2'b10,
    OP_DIVS = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_FIX  = 2'b10,
    ST_HOLD = 2'b11
  } state_e;

  // Two's-complement conditional negate; callers size-cast the result to their width.
  function automatic logic [MAG_W-1:0] cond_neg(input logic [MAG_W-1:0] value, input logic neg);
    logic [MAG_W-1:0] one;
    one = {{(MAG_W-1){1'b0}}, 1'b1};
    if (neg) begin
      return ~value + one;
    end else begin
      return value;
    end
  endfunction

endpackage

// File: rtl/mcycle_step.sv
// One radix-2 iteration: shift-add multiply or restoring shift-subtract divide.
// Accumulator layout: {hi, lo}; lo holds multiplier / dividend bits being consumed.
module mcycle_step #(
  parameter int WIDTH = 32
) (
  input  logic                 is_div_i,
  input  logic [2*WIDTH-1:0]   acc_i,
  input  logic [WIDTH-1:0]     operand_i,
  output logic [2*WIDTH-1:0]   acc_o
);

  logic [WIDTH:0] sum_s;
  logic [WIDTH:0] rem_shift_s;
  logic [WIDTH:0] diff_s;

  // Single-step datapath; bit WIDTH of diff_s is the borrow of the trial subtract.
  always_comb begin
    sum_s       = {1'b0, acc_i[2*WIDTH-1:WIDTH]} +
                  (acc_i[0] ? {1'b0, operand_i} : {(WIDTH+1){1'b0}});
    rem_shift_s = acc_i[2*WIDTH-1:WIDTH-1];
    diff_s      = rem_shift_s - {1'b0, operand_i};
    if (is_div_i) begin
      if (!diff_s[WIDTH]) begin
        acc_o = {diff_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end else begin
        acc_o = {rem_shift_s[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_o = {sum_s, acc_i[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/mcycle_unit.sv
// Multi-cycle multiply/divide E-stage unit with valid/ack writeback and RAW hazard output.
// Optional feature macro: MCYCLE_EARLY_EXIT_EN (early termination of multiplies).
module mcycle_unit
  import mcycle_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] operand1_i,
  input  logic [WIDTH-1:0] operand2_i,
  input  logic [TAG_W-1:0] tag_i,
  input  logic [TAG_W-1:0] ra1_i,
  input  logic [TAG_W-1:0] ra2_i,
  input  logic             result_ack_i,
  input  logic             abort_i,
  output logic             busy_o,
  output logic             result_valid_o,
  output logic [WIDTH-1:0] result_o,
  output logic [WIDTH-1:0] result2_o,
  output logic [TAG_W-1:0] tag_o,
  output logic             div_by_zero_o,
  output logic             hazard_o
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam int ACC_W = 2 * WIDTH;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  op_e                op_q;
  logic               sign1_q, sign2_q, dbz_q;
  logic [TAG_W-1:0]   tag_q;
  logic [WIDTH-1:0]   opb_q;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH-1:0]   result2_q, result2_d;

  logic               is_div_q_s;
  logic               in_is_div_s, in_sign1_s, in_sign2_s, in_dbz_s;
  logic               launch_s, launch_fix_s;
  logic [WIDTH-1:0]   mag1_s, mag2_s;
  logic [ACC_W-1:0]   launch_acc_s;
  logic [ACC_W-1:0]   step_acc_s;
  logic [ACC_W-1:0]   prod_s;
  logic [WIDTH-1:0]   quo_s, rem_s;

  assign is_div_q_s  = (op_q == OP_DIVU) || (op_q == OP_DIVS);
  assign in_is_div_s = op_i[1];
  assign in_sign1_s  = op_i[0] & operand1_i[WIDTH-1];
  assign in_sign2_s  = op_i[0] & operand2_i[WIDTH-1];
  assign in_dbz_s    = in_is_div_s && (operand2_i == {WIDTH{1'b0}});
  assign mag1_s      = WIDTH'(cond_neg(MAG_W'(operand1_i), in_sign1_s));
  assign mag2_s      = WIDTH'(cond_neg(MAG_W'(operand2_i), in_sign2_s));

  // Start is honoured in IDLE, or in HOLD together with the ack; abort always wins.
  assign launch_s = start_i && !abort_i &&
                    ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && result_ack_i));

`ifdef MCYCLE_EARLY_EXIT_EN
  assign launch_fix_s = in_dbz_s || (!in_is_div_s && (operand1_i == {WIDTH{1'b0}}));
`else
  assign launch_fix_s = in_dbz_s;
`endif

  // Divide by zero keeps the raw dividend so it can be returned unchanged as Result2.
  assign launch_acc_s = in_dbz_s ? {{WIDTH{1'b0}}, operand1_i} : {{WIDTH{1'b0}}, mag1_s};

  assign prod_s = ACC_W'(cond_neg(MAG_W'(acc_q), sign1_q ^ sign2_q));
  assign quo_s  = WIDTH'(cond_neg(MAG_W'(acc_q[WIDTH-1:0]), sign1_q ^ sign2_q));
  assign rem_s  = WIDTH'(cond_neg(MAG_W'(acc_q[ACC_W-1:WIDTH]), sign1_q));

  mcycle_step #(.WIDTH(WIDTH)) u_step (
    .is_div_i  (is_div_q_s),
    .acc_i     (acc_q),
    .operand_i (opb_q),
    .acc_o     (step_acc_s)
  );

  // Next-state, iteration and sign-fix logic.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    acc_d     = acc_q;
    result_d  = result_q;
    result2_d = result2_q;
    if (abort_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = launch_s ? (launch_fix_s ? ST_FIX : ST_RUN) : ST_IDLE;
          acc_d   = launch_s ? launch_acc_s : acc_q;
          cnt_d   = {CNT_W{1'b0}};
        end
        ST_RUN: begin
          acc_d = step_acc_s;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            state_d = ST_FIX;
`ifdef MCYCLE_EARLY_EXIT_EN
          end else if (!is_div_q_s &&
                       ((step_acc_s[WIDTH-1:0] & ({WIDTH{1'b1}} >> (int'(cnt_q) + 1)))
                        == {WIDTH{1'b0}})) begin
            // Remaining multiplier bits are zero: finish the outstanding shifts at once.
            acc_d   = step_acc_s >> (WIDTH - 1 - int'(cnt_q));
            state_d = ST_FIX;
`endif
          end else begin
            state_d = ST_RUN;
          end
        end
        ST_FIX: begin
          state_d = ST_HOLD;
          if (dbz_q) begin
            result_d  = {WIDTH{1'b1}};
            result2_d = acc_q[WIDTH-1:0];
          end else if (is_div_q_s) begin
            result_d  = quo_s;
            result2_d = rem_s;
          end else begin
            result_d  = prod_s[WIDTH-1:0];
            result2_d = prod_s[ACC_W-1:WIDTH];
          end
        end
        ST_HOLD: begin
          state_d = result_ack_i ? (launch_s ? (launch_fix_s ? ST_FIX : ST_RUN) : ST_IDLE)
                                 : ST_HOLD;
          acc_d   = launch_s ? launch_acc_s : acc_q;
          cnt_d   = {CNT_W{1'b0}};
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
  end

  // FSM state, datapath and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      cnt_q     <= {CNT_W{1'b0}};
      acc_q     <= {ACC_W{1'b0}};
      result_q  <= {WIDTH{1'b0}};
      result2_q <= {WIDTH{1'b0}};
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      acc_q     <= acc_d;
      result_q  <= result_d;
      result2_q <= result2_d;
    end
  end

  // Operation context captured with each accepted Start.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q    <= OP_MULU;
      sign1_q <= 1'b0;
      sign2_q <= 1'b0;
      dbz_q   <= 1'b0;
      tag_q   <= {TAG_W{1'b0}};
      opb_q   <= {WIDTH{1'b0}};
    end else if (launch_s) begin
      op_q    <= op_e'(op_i);
      sign1_q <= in_sign1_s;
      sign2_q <= in_sign2_s;
      dbz_q   <= in_dbz_s;
      tag_q   <= tag_i;
      opb_q   <= mag2_s;
    end
  end

  assign busy_o         = (state_q != ST_IDLE);
  assign result_valid_o = (state_q == ST_HOLD);
  assign div_by_zero_o  = dbz_q && (state_q == ST_HOLD);
  assign result_o       = result_q;
  assign result2_o      = result2_q;
  assign tag_o          = tag_q;
  assign hazard_o       = busy_o && ((tag_q == ra1_i) || (tag_q == ra2_i));

endmodule
